hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
Parametrised pipeline hazard controller for the next-generation 5-stage MIPS core; replaces the fixed two-stage comparator hazard logic. It keeps a shift-register scoreboard of in-flight destination registers, generates per-operand forwarding selects and load-use/branch-operand stalls, redirect flushes, and a hold sequence for a multi-cycle EX unit (MULT/DIV). It sits beside the ID stage and drives the PC, IF_ID, ID_EX and EX_MEM enables.

Parameters:
REG_AW, 5, register-address width (2**REG_AW GPRs; register 0 never forwarded)
DEPTH, 3, tracked stages after ID (1=EX, 2=MEM, ..., DEPTH=WB)
LOAD_STAGE, 2, first stage whose entry holds valid load data (2..DEPTH)
MC_LAT, 4, EX occupancy of a multi-cycle op in cycles (>=2)
CNT_W, 16, stall-cycle counter width

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous active-high reset
id_valid  in  1  real instruction in ID (0 = bubble/flushed)
id_rs, id_rt  in  REG_AW  source register fields
id_rs_used, id_rt_used  in  1  operand actually read
id_dst  in  REG_AW  destination (after RegDst mux)
id_regwrite  in  1  instruction writes id_dst
id_memread  in  1  instruction is a load
id_mc  in  1  multi-cycle EX op
id_branch  in  1  branch compared in ID (equality detector)
id_redirect  in  1  taken branch or jump resolved in ID
fwd_a_sel, fwd_b_sel  out  FS_W=$clog2(DEPTH+1)  0 = register file, k = stage k result
stall_front  out  1  hold PC and IF_ID
idex_bubble  out  1  load zeros/NOP into ID_EX
idex_hold  out  1  ID_EX keeps contents
exmem_bubble  out  1  load NOP into EX_MEM
flush_ifid  out  1  clear IF_ID
mc_busy  out  1  multi-cycle op occupying EX
stall_cycles  out  CNT_W  saturating count of cycles with stall_front=1

Behaviour:
- Scoreboard entry k in 1..DEPTH: {valid, wen, load, dst}. Async reset clears all entries, mc counter and stall_cycles; every output is 0 out of reset.
- Match(src,k): src used, src!=0, entry k valid & wen & dst==src. Youngest match (smallest k) wins.
- fwd_x_sel = youngest matching k, else 0. Combinational, 0-cycle latency.
- Load-use hazard: youngest match k has load=1 and k<LOAD_STAGE.
- Branch hazard (id_branch=1): youngest match k==1, or load=1 with k<=LOAD_STAGE.
- mc counter: loads MC_LAT-1 when an id_mc instruction advances into EX; decrements each cycle while nonzero. mc_busy = counter!=0.
- Priority per cycle (highest first):
  1. mc_busy: stall_front=1, idex_hold=1, exmem_bubble=1; entry1 holds, entry2 <= invalid, entries 3..DEPTH shift.
  2. data hazard (load-use or branch, only if id_valid): stall_front=1, idex_bubble=1; entry1 <= invalid, others shift.
  3. normal: entry1 <= {id_valid, id_regwrite, id_memread, id_dst}; entry k <= entry k-1.
- flush_ifid = id_valid & id_redirect & !stall_front. A stalled redirect is re-presented next cycle and flushes then.
- Entries with dst==0 are recorded but never matched.
- On the final mc cycle (counter==1), mc_busy stays 1; the next cycle shifts normally with the mc result in entry 2.
- stall_cycles increments when stall_front=1 and saturates at all-ones.
- Rst asserted mid-operation (including mid-mc hold): immediate clear, no pending redirect retained.

Decomposition:
- Shared package hazard_pkg: scoreboard entry struct, FWD_RF=0 constant, FS_W function.
- One sub-module, sb_match: per-operand youngest-match priority encoder, instanced twice, returning {hit, k, load}.

Test Plan:
1. ADD $3 issued, then SUB reading $3 -> fwd_a_sel=1, no stall; one cycle later, a reader of $3 -> sel=2.
2. LW $5, then ADD rs=$5 -> one cycle stall_front=1/idex_bubble=1, then fwd_a_sel=2, stall_cycles=1.
3. ADD $4, then BEQ $4,$0 -> 1-cycle stall; LW $4, then BEQ -> 2-cycle stall; flush_ifid asserts only after the stall clears if taken.
4. MULT (id_mc, MC_LAT=4) -> mc_busy, stall_front, idex_hold high exactly 3 cycles, exmem_bubble each cycle, stall_cycles=3.
5. Writer to $0, then reader of $0 -> fwd sel=0, no stall; DEPTH=5 build: writer in stage 5 -> sel=5.
6. Rst pulse during cycle 2 of mc hold -> all outputs 0 in the same cycle, scoreboard empty, counter 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: entry flags, the
// register-file forwarding code and the forward-select width function.
package hazard_pkg;

  localparam int FWD_RF = 0;

  // Per-stage scoreboard flags; the destination field is carried alongside
  // because its width follows the core's register-address parameter.
  typedef struct packed {
    logic valid;
    logic wen;
    logic load;
  } sb_flags_t;

  function automatic int fs_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sb_match.sv
// Youngest-match priority encoder for one source operand against the
// in-flight destination scoreboard; returns hit, stage index and load flag.
module sb_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int FS_W   = fs_w(DEPTH)
) (
  input  logic [REG_AW-1:0]            src,
  input  logic                         used,
  input  sb_flags_t [DEPTH:1]          flags,
  input  logic [DEPTH:1][REG_AW-1:0]   dst,
  output logic                         hit,
  output logic [FS_W-1:0]              k,
  output logic                         load
);

  // Scan oldest to youngest so the youngest matching stage is the last writer.
  always_comb begin
    hit  = 1'b0;
    k    = FS_W'(FWD_RF);
    load = 1'b0;
    if (used && src != '0) begin
      for (int i = DEPTH; i >= 1; i--) begin
        if (flags[i].valid && flags[i].wen && dst[i] == src) begin
          hit  = 1'b1;
          k    = FS_W'(i);
          load = flags[i].load;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller beside ID: destination scoreboard, operand
// forwarding selects, load-use/branch stalls, redirect flush and MC/DIV hold.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rs,
  input  logic [REG_AW-1:0]         id_rt,
  input  logic                      id_rs_used,
  input  logic                      id_rt_used,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      id_mc,
  input  logic                      id_branch,
  input  logic                      id_redirect,
  output logic [fs_w(DEPTH)-1:0]    fwd_a_sel,
  output logic [fs_w(DEPTH)-1:0]    fwd_b_sel,
  output logic                      stall_front,
  output logic                      idex_bubble,
  output logic                      idex_hold,
  output logic                      exmem_bubble,
  output logic                      flush_ifid,
  output logic                      mc_busy,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam int FS_W = fs_w(DEPTH);
  localparam int MC_W = $clog2(MC_LAT);

  sb_flags_t [DEPTH:1]          flags;
  logic [DEPTH:1][REG_AW-1:0]   dst;
  logic [MC_W-1:0]              mc_cnt;

  logic            hit_a, hit_b, load_a, load_b;
  logic [FS_W-1:0] k_a, k_b;
  logic            lu_a, lu_b, br_a, br_b, data_hz;

  sb_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FS_W(FS_W)) u_match_a (
    .src(id_rs), .used(id_rs_used), .flags(flags), .dst(dst),
    .hit(hit_a), .k(k_a), .load(load_a)
  );

  sb_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FS_W(FS_W)) u_match_b (
    .src(id_rt), .used(id_rt_used), .flags(flags), .dst(dst),
    .hit(hit_b), .k(k_b), .load(load_b)
  );

  always_comb begin
    fwd_a_sel    = k_a;
    fwd_b_sel    = k_b;
    mc_busy      = (mc_cnt != '0);
    lu_a         = hit_a && load_a && (int'(k_a) < LOAD_STAGE);
    lu_b         = hit_b && load_b && (int'(k_b) < LOAD_STAGE);
    // The ID equality detector needs the value one stage earlier than EX does.
    br_a         = id_branch && hit_a &&
                   (k_a == FS_W'(1) || (load_a && int'(k_a) <= LOAD_STAGE));
    br_b         = id_branch && hit_b &&
                   (k_b == FS_W'(1) || (load_b && int'(k_b) <= LOAD_STAGE));
    data_hz      = id_valid && (lu_a || lu_b || br_a || br_b);
    stall_front  = mc_busy || data_hz;
    idex_bubble  = !mc_busy && data_hz;
    idex_hold    = mc_busy;
    exmem_bubble = mc_busy;
    flush_ifid   = !Rst && id_valid && id_redirect && !stall_front;
  end

  // Stage boundary: scoreboard shift, multi-cycle counter, stall statistics.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      flags        <= '0;
      dst          <= '0;
      mc_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      if (stall_front && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      // While EX is held the MC op stays in entry 1 and a bubble enters MEM.
      for (int k = 2; k <= DEPTH; k++) begin
        dst[k]   <= dst[k-1];
        flags[k] <= (mc_busy && k == 2) ? '0 : flags[k-1];
      end
      if (mc_busy) begin
        mc_cnt <= mc_cnt - MC_W'(1);
      end else if (data_hz) begin
        flags[1] <= '0;
      end else begin
        flags[1] <= '{valid: id_valid, wen: id_regwrite, load: id_memread};
        dst[1]   <= id_dst;
        if (id_valid && id_mc)
          mc_cnt <= MC_W'(MC_LAT - 1);
      end
    end
  end

endmodule
